// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: sequencer for a signed int8 dot product. It drives one
// external MAC_LAT-deep multiply-accumulate pipeline (y = acc + a*b).
// Consecutive operands rotate over MAC_LAT independent partial-sum lanes, so a
// lane is reissued only once its previous result has come back. This lets the
// block issue one MAC per cycle with no bubbles.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, len, busy           job request / length / in-progress flag
//   elem_valid/ready/a/b       operand stream (valid/ready handshake)
//   mac_in_valid, mac_a/b/acc  issue side of the MAC pipeline
//   mac_out_valid, mac_y       return side of the MAC pipeline
//   done, result               completion pulse and final 32-bit sum
module dot_product_ctrl #(
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    elem_valid,
  output logic                    elem_ready,
  input  logic signed [7:0]       elem_a,
  input  logic signed [7:0]       elem_b,
  output logic                    mac_in_valid,
  output logic signed [7:0]       mac_a,
  output logic signed [7:0]       mac_b,
  output logic signed [31:0]      mac_acc,
  input  logic                    mac_out_valid,
  input  logic signed [31:0]      mac_y,
  output logic                    done,
  output logic signed [31:0]      result
);

  localparam int LANE_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int CNT_W  = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, REDUCE} state_e;

  state_e                           state_q, state_d;
  logic [LEN_W-1:0]                 rem_q, rem_d;
  logic [CNT_W-1:0]                 infl_q, infl_d;
  logic [LANE_W-1:0]                issue_lane_q, issue_lane_d;
  logic [MAC_LAT-1:0][LANE_W-1:0]   tag_q, tag_d;
  logic [MAC_LAT-1:0][31:0]         partial_q, partial_d;
  logic                             done_q, done_d;
  logic [31:0]                      result_q, result_d;

  logic              issue, ret;
  logic [LANE_W-1:0] ret_lane;
  logic [31:0]       sum;

  assign elem_ready   = (state_q == STREAM);
  assign busy         = (state_q != IDLE);
  assign issue        = elem_valid && elem_ready;
  assign mac_in_valid = issue;
  assign mac_a        = elem_a;
  assign mac_b        = elem_b;
  // The oldest tag leaving the shift register names the lane of the returning result.
  assign ret_lane     = tag_q[MAC_LAT-1];
  // A result with nothing in flight is spurious and is dropped.
  assign ret          = mac_out_valid && (infl_q != '0);
  // If a lane's result returns in the same cycle the lane is reissued, the
  // stored partial is stale. Forward the returning value instead.
  assign mac_acc      = (mac_out_valid && ret_lane == issue_lane_q) ? mac_y
                                                                    : partial_q[issue_lane_q];
  assign done         = done_q;
  assign result       = result_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < MAC_LAT; i++) sum = sum + partial_q[i];
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    issue_lane_d = issue_lane_q;
    partial_d    = partial_q;
    done_d       = 1'b0;
    result_d     = result_q;
    infl_d       = infl_q + CNT_W'(issue) - CNT_W'(ret);

    // Tag pipe advances every cycle. Only tags pushed alongside an issue are
    // ever consumed, because returns are gated by the in-flight count.
    tag_d[0] = issue_lane_q;
    for (int i = 1; i < MAC_LAT; i++) tag_d[i] = tag_q[i-1];

    if (ret) partial_d[ret_lane] = mac_y;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d        = len;
          partial_d    = '0;
          issue_lane_d = '0;
          infl_d       = '0;
          state_d      = (len != '0) ? STREAM : REDUCE;
        end
      end
      STREAM: begin
        if (issue) begin
          rem_d        = rem_q - LEN_W'(1);
          issue_lane_d = (issue_lane_q == LANE_W'(MAC_LAT-1)) ? '0
                                                             : issue_lane_q + LANE_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_d == '0) state_d = REDUCE;
      end
      REDUCE: begin
        result_d = sum;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      infl_q       <= '0;
      issue_lane_q <= '0;
      tag_q        <= '0;
      partial_q    <= '0;
      done_q       <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      infl_q       <= infl_d;
      issue_lane_q <= issue_lane_d;
      tag_q        <= tag_d;
      partial_q    <= partial_d;
      done_q       <= done_d;
      result_q     <= result_d;
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl. It includes a behavioural MAC pipeline, a
// per-cycle reference model built from job-level timing rules, and directed
// jobs with literal expected results.
module tb_dot_product_ctrl;
  localparam int MAC_LAT = 3;
  localparam int LEN_W   = 9;

  logic clk = 0, rst_n = 0, start = 0, elem_valid = 0;
  logic [LEN_W-1:0] len = '0;
  logic signed [7:0] elem_a = 0, elem_b = 0;
  logic busy, elem_ready, mac_in_valid, mac_out_valid, done;
  logic signed [7:0] mac_a, mac_b;
  logic signed [31:0] mac_acc, mac_y, result;

  dot_product_ctrl #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_a(elem_a), .elem_b(elem_b),
    .mac_in_valid(mac_in_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .mac_out_valid(mac_out_valid), .mac_y(mac_y), .done(done), .result(result));

  always #5 clk = ~clk;

  function automatic int mul(input logic signed [7:0] a, input logic signed [7:0] b);
    int x, y;
    x = a; y = b;
    return x * y;
  endfunction

  // External MAC pipeline: y = acc + a*b, MAC_LAT cycles later.
  logic [MAC_LAT:1] pv;
  logic signed [31:0] py [1:MAC_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 1; i <= MAC_LAT; i++) py[i] <= 0;
    end else begin
      pv[1] <= mac_in_valid;
      py[1] <= mac_acc + mul(mac_a, mac_b);
      for (int i = 2; i <= MAC_LAT; i++) begin
        pv[i] <= pv[i-1];
        py[i] <= py[i-1];
      end
    end
  end
  assign mac_out_valid = pv[MAC_LAT];
  assign mac_y         = py[MAC_LAT];

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state and job observations.
  int cyc = 0, m_done_at = -1, m_rem = 0, m_sum = 0, m_result = 0;
  bit m_active = 0;
  int start_cyc = 0, last_done_cyc = 0, done_cnt = 0, last_result = 0;
  int mac_cnt = 0, busy_cnt = 0, ready_cnt = 0;

  always @(negedge clk) begin
    bit exp_done, exp_ready, exp_miv;
    if (!rst_n) begin
      m_active = 0; m_result = 0; m_rem = 0; m_done_at = -1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(elem_ready), 0);
      chk("rst_mac_in_valid", int'(mac_in_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_result", result, 0);
    end else begin
      exp_done = m_active && (cyc == m_done_at);
      if (exp_done) begin
        m_active = 0;
        m_result = m_sum;
      end
      exp_ready = m_active && (m_rem > 0);
      exp_miv   = exp_ready && elem_valid;
      chk("busy", int'(busy), int'(m_active));
      chk("elem_ready", int'(elem_ready), int'(exp_ready));
      chk("mac_in_valid", int'(mac_in_valid), int'(exp_miv));
      chk("done", int'(done), int'(exp_done));
      chk("result", result, m_result);
      if (exp_miv) begin
        chk("mac_a", int'(mac_a), int'(elem_a));
        chk("mac_b", int'(mac_b), int'(elem_b));
      end
      if (done) begin
        done_cnt++; last_done_cyc = cyc; last_result = result;
      end
      if (mac_in_valid) mac_cnt++;
      if (busy) busy_cnt++;
      if (elem_ready) ready_cnt++;
      if (exp_miv) begin
        m_sum = m_sum + mul(elem_a, elem_b);
        m_rem--;
        if (m_rem == 0) m_done_at = cyc + 5;
      end
      if (!m_active && start) begin
        m_active = 1; m_rem = int'(len); m_sum = 0;
        if (len == 0) m_done_at = cyc + 2;
        start_cyc = cyc; mac_cnt = 0; busy_cnt = 0; ready_cnt = 0;
      end
    end
    cyc++;
  end

  logic signed [7:0] va [0:15];
  logic signed [7:0] vb [0:15];

  task automatic run_job(input int n, input bit gap, input bit mid_start, input int abort_after);
    int i, k;
    @(posedge clk); #1 start = 1; len = LEN_W'(n);
    @(posedge clk); #1 start = 0;
    i = 0; k = 0;
    while (i < n && k < 200) begin
      if (abort_after >= 0 && i == abort_after) break;
      if (gap && (k % 2 == 1)) elem_valid = 0;
      else begin
        elem_valid = 1; elem_a = va[i]; elem_b = vb[i];
        if (elem_ready) i++;
      end
      if (mid_start && k == 2) begin start = 1; len = LEN_W'(2); end
      else start = 0;
      k++;
      @(posedge clk); #1;
    end
    elem_valid = 0; start = 0;
    if (k >= 200) chk("stream_timeout", 0, 1);
  endtask

  task automatic wait_done(input int base);
    int g;
    g = 0;
    while (done_cnt == base && g < 60) begin
      @(posedge clk); #1; g++;
    end
    chk("done_seen", int'(done_cnt != base), 1);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Job 1: [1,2,3,4].[5,6,7,8] = 70, back-to-back.
    for (int i = 0; i < 4; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 5); end
    base = done_cnt;
    run_job(4, 0, 0, -1); wait_done(base);
    chk("j1_result", last_result, 70);
    chk("j1_latency", last_done_cyc - start_cyc, 9);
    chk("j1_busy_cycles", busy_cnt, 8);
    chk("j1_mac_count", mac_cnt, 4);

    // Job 2: seven (-128)*(-128), every lane hits the forwarding path.
    for (int i = 0; i < 7; i++) begin va[i] = -8'sd128; vb[i] = -8'sd128; end
    base = done_cnt;
    run_job(7, 0, 0, -1); wait_done(base);
    chk("j2_result", last_result, 114688);
    chk("j2_latency", last_done_cyc - start_cyc, 12);

    // Job 3: job 1 vectors with valid low on alternate cycles.
    for (int i = 0; i < 4; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 5); end
    base = done_cnt;
    run_job(4, 1, 0, -1); wait_done(base);
    chk("j3_result", last_result, 70);
    chk("j3_mac_count", mac_cnt, 4);

    // Job 4: zero length.
    base = done_cnt;
    run_job(0, 0, 0, -1); wait_done(base);
    chk("j4_latency", last_done_cyc - start_cyc, 2);
    chk("j4_result", last_result, 0);
    chk("j4_ready_cycles", ready_cnt, 0);

    // Job 5: start pulsed mid-stream is ignored; 5+12+21+32-50 = 20.
    va[4] = 8'sd5; vb[4] = -8'sd10;
    base = done_cnt;
    run_job(5, 0, 1, -1); wait_done(base);
    chk("j5_result", last_result, 20);
    chk("j5_latency", last_done_cyc - start_cyc, 10);
    repeat (10) @(posedge clk); #1;
    chk("j5_no_extra_done", done_cnt - base, 1);

    // Job 6: reset after 2 of 5 elements, then a fresh single-element job.
    base = done_cnt;
    run_job(5, 0, 0, 2);
    rst_n = 0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(elem_ready), 0);
    chk("abort_miv", int'(mac_in_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", result, 0);
    repeat (2) @(posedge clk); #1 rst_n = 1;
    repeat (15) @(posedge clk); #1;
    chk("abort_no_done", done_cnt - base, 0);
    va[0] = 8'sd3; vb[0] = -8'sd4;
    base = done_cnt;
    run_job(1, 0, 0, -1); wait_done(base);
    chk("j6_result", last_result, -12);
    chk("j6_latency", last_done_cyc - start_cyc, 6);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
